mul_div_unit: RTL



---
 rtl/mul_div_unit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative multiply/divide unit that sits next to the combinational ALU of
// the MIPS datapath. It executes MULT, MULTU, DIV and DIVU one bit per cycle
// and keeps the results in the HI/LO registers for MFHI/MFLO.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     launch an operation (sampled only when not busy)
//   opSel     2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
//   operand1  multiplicand / dividend (rs)
//   operand2  multiplier / divisor (rt)
//   busy      operation in progress, pipeline must stall
//   done      one-cycle pulse, HI/LO were updated on the previous edge
//   hi        HI register (product upper half / remainder)
//   lo        LO register (product lower half / quotient)
//
// Optional feature, macro MDU_HILO_WRITE_EN:
//   hiWrite, loWrite, wrData   direct HI/LO writes for MTHI/MTLO, applied
//                              at the next edge while the unit is not busy.
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int data_width = 32,
    parameter int sel_width  = 2,
    parameter int iter_count = data_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [sel_width-1:0]  opSel,
    input  logic [data_width-1:0] operand1,
    input  logic [data_width-1:0] operand2,
`ifdef MDU_HILO_WRITE_EN
    input  logic                  hiWrite,
    input  logic                  loWrite,
    input  logic [data_width-1:0] wrData,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [data_width-1:0] hi,
    output logic [data_width-1:0] lo
);

    localparam int W  = data_width;
    localparam int CW = $clog2(iter_count + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]     state_q,   state_d;
    logic [CW-1:0]  cnt_q,     cnt_d;
    logic           is_div_q,  is_div_d;
    logic [W-1:0]   mag1_q,    mag1_d;
    logic [W-1:0]   mag2_q,    mag2_d;
    logic           res_neg_q, res_neg_d;
    logic           rem_neg_q, rem_neg_d;
    logic [2*W-1:0] acc_q,     acc_d;
    logic [W-1:0]   hi_q,      hi_d;
    logic [W-1:0]   lo_q,      lo_d;

    // Operand conditioning at the start edge: signed ops work on magnitudes
    // and remember the signs for the final correction step.
    logic         in_signed;
    logic         in_neg1;
    logic         in_neg2;
    logic [W-1:0] in_mag1;
    logic [W-1:0] in_mag2;

    assign in_signed = ~opSel[0];
    assign in_neg1   = in_signed & operand1[W-1];
    assign in_neg2   = in_signed & operand2[W-1];
    assign in_mag1   = in_neg1 ? (W'(0) - operand1) : operand1;
    assign in_mag2   = in_neg2 ? (W'(0) - operand2) : operand2;

    // Shift-add multiply step. The accumulator holds {partial product,
    // remaining multiplier bits}; the carry of the upper add is shifted in
    // from the top so no bit of the 2W-bit product is lost.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag1_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Restoring divide step. The accumulator holds {partial remainder,
    // dividend bits becoming quotient bits}. The trial remainder is W+1 bits
    // wide because the shifted remainder can exceed W bits before the
    // subtraction. A zero divisor makes every trial succeed, which yields an
    // all-ones quotient; the final step overrides that case explicitly.
    logic [W:0]     div_top;
    logic           div_ge;
    logic [W-1:0]   div_sub;
    logic [2*W-1:0] div_next;

    assign div_top  = acc_q[2*W-1:W-1];
    assign div_ge   = div_top >= {1'b0, mag2_q};
    assign div_sub  = div_top[W-1:0] - mag2_q;
    assign div_next = div_ge ? {div_sub, acc_q[W-2:0], 1'b1}
                             : {div_top[W-1:0], acc_q[W-2:0], 1'b0};

    // Sign correction of the raw magnitude results. For a divide by zero the
    // remainder reproduces the original dividend (magnitude re-signed) and
    // the quotient is forced to all ones, independent of operand signs.
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   quo_fixed;
    logic [W-1:0]   rem_fixed;
    logic [W-1:0]   fix_hi;
    logic [W-1:0]   fix_lo;
    logic           div_by_zero;

    assign prod_fixed  = res_neg_q ? ({(2*W){1'b0}} - acc_q) : acc_q;
    assign quo_fixed   = res_neg_q ? (W'(0) - acc_q[W-1:0]) : acc_q[W-1:0];
    assign rem_fixed   = rem_neg_q ? (W'(0) - acc_q[2*W-1:W]) : acc_q[2*W-1:W];
    assign div_by_zero = (mag2_q == '0);

    always_comb begin
        fix_hi = prod_fixed[2*W-1:W];
        fix_lo = prod_fixed[W-1:0];
        if (is_div_q) begin
            if (div_by_zero) begin
                fix_hi = rem_neg_q ? (W'(0) - mag1_q) : mag1_q;
                fix_lo = '1;
            end else begin
                fix_hi = rem_fixed;
                fix_lo = quo_fixed;
            end
        end
    end

    // Next-state logic. IDLE and DONE both accept a new start, which is what
    // allows back-to-back operations without a dead cycle. The first CALC
    // cycle loads the accumulator from the latched magnitudes; the remaining
    // iter_count CALC cycles each retire one bit. HI/LO change only on the
    // FIX exit edge (or by a direct write while not busy).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        mag1_d    = mag1_q;
        mag2_d    = mag2_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
`ifdef MDU_HILO_WRITE_EN
                if (hiWrite) begin
                    hi_d = wrData;
                end
                if (loWrite) begin
                    lo_d = wrData;
                end
`endif
                if (start) begin
                    state_d   = ST_CALC;
                    cnt_d     = '0;
                    is_div_d  = opSel[1];
                    mag1_d    = in_mag1;
                    mag2_d    = in_mag2;
                    res_neg_d = in_neg1 ^ in_neg2;
                    rem_neg_d = in_neg1;
                end
            end

            ST_CALC: begin
                if (cnt_q == '0) begin
                    acc_d = is_div_q ? {{W{1'b0}}, mag1_q} : {{W{1'b0}}, mag2_q};
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                end
                if (cnt_q == CW'(iter_count)) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation without touching HI/LO
    // other than clearing them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            mag1_q    <= '0;
            mag2_q    <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            mag1_q    <= mag1_d;
            mag2_q    <= mag2_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
